// File: rtl/nn_layer_weight_loader.sv
// -----------------------------------------------------------------------------
// nn_layer_weight_loader
//
// Purpose:
//   Steps the neural network through its layers (0..LAST_LAYER). For each
//   layer it streams 16 weights from an external 1024x8 synchronous-read
//   block RAM and routes each weight to one of four neuron units. After the
//   last weight it pulses sum_trigger, then waits for the units' done before
//   moving to the next layer.
//
//   The block has three parts:
//     - layer sequencer (IDLE / WAIT_DONE)
//     - RAM read driver (IDLE / READ / DRAIN / TRIG)
//     - weight mux (combinational broadcast plus per-unit write decode)
//
// Ports:
//   clk                 in   1  rising-edge clock
//   reset               in   1  synchronous, active-high
//   start               in   1  begins a full network pass (honoured in IDLE only)
//   done                in   1  neuron units finished the current layer
//   ram_out             in   8  RAM read data, valid one cycle after address
//   RAM_address         out 10  RAM read address
//   layer               out  2  current layer index
//   layer_sel           out  1  0 for layer 0, 1 otherwise
//   RAM_Controll_Start  out  1  one-cycle pulse launching a layer's weight load
//   unit_sel            out  2  destination unit of the weight on ram_out
//   unit_address        out  2  weight slot within that unit
//   write               out  1  weight-valid strobe
//   sum_trigger         out  1  pulse after the last weight of a layer
//   weight0..weight3    out  8  weight data to units 0..3 (broadcast)
//   write0..write3      out  1  per-unit write strobes
// -----------------------------------------------------------------------------
module nn_layer_weight_loader #(
    parameter int LAST_LAYER   = 2,
    parameter int LAYER_STRIDE = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       done,
    input  logic [7:0] ram_out,
    output logic [9:0] RAM_address,
    output logic [1:0] layer,
    output logic       layer_sel,
    output logic       RAM_Controll_Start,
    output logic [1:0] unit_sel,
    output logic [1:0] unit_address,
    output logic       write,
    output logic       sum_trigger,
    output logic [7:0] weight0,
    output logic [7:0] weight1,
    output logic [7:0] weight2,
    output logic [7:0] weight3,
    output logic       write0,
    output logic       write1,
    output logic       write2,
    output logic       write3
);

    localparam logic [1:0] LAST_W   = 2'(LAST_LAYER);
    localparam logic [9:0] STRIDE_W = 10'(LAYER_STRIDE);
    localparam logic [3:0] LAST_K   = 4'd15;

    // -------------------------------------------------------------------------
    // Layer sequencer
    // -------------------------------------------------------------------------
    typedef enum logic {
        SEQ_IDLE,
        SEQ_WAIT_DONE
    } seq_state_t;

    seq_state_t r_seq_state;
    logic [1:0] r_layer;
    logic       r_layer_sel;
    logic       r_ram_ctrl_start;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_seq_state      <= SEQ_IDLE;
            r_layer          <= 2'd0;
            r_layer_sel      <= 1'b0;
            r_ram_ctrl_start <= 1'b0;
        end else begin
            // Load launch is a single-cycle pulse.
            r_ram_ctrl_start <= 1'b0;
            case (r_seq_state)
                SEQ_IDLE: begin
                    if (start) begin
                        r_layer          <= 2'd0;
                        r_layer_sel      <= 1'b0;
                        r_ram_ctrl_start <= 1'b1;
                        r_seq_state      <= SEQ_WAIT_DONE;
                    end
                end
                SEQ_WAIT_DONE: begin
                    if (done) begin
                        if (r_layer < LAST_W) begin
                            r_layer          <= r_layer + 2'd1;
                            // Every layer past 0 takes its inputs from the
                            // previous layer's results.
                            r_layer_sel      <= 1'b1;
                            r_ram_ctrl_start <= 1'b1;
                        end else begin
                            // Final layer: layer index is left on LAST_LAYER.
                            r_seq_state <= SEQ_IDLE;
                        end
                    end
                end
                default: r_seq_state <= SEQ_IDLE;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // RAM read driver
    // -------------------------------------------------------------------------
    typedef enum logic [1:0] {
        RD_IDLE,
        RD_READ,
        RD_DRAIN,
        RD_TRIG
    } rd_state_t;

    rd_state_t  r_rd_state;
    logic [3:0] r_k;            // weight index of the address currently issued
    logic [9:0] r_ram_address;
    logic [1:0] r_unit_sel;
    logic [1:0] r_unit_address;
    logic       r_write;
    logic       r_sum_trigger;
    logic [9:0] w_layer_base;

    // Layer is sampled in the same cycle as the launch pulse, when the
    // sequencer has already moved it to the layer being loaded.
    assign w_layer_base = 10'(r_layer) * STRIDE_W;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_state     <= RD_IDLE;
            r_k            <= 4'd0;
            r_ram_address  <= 10'd0;
            r_unit_sel     <= 2'd0;
            r_unit_address <= 2'd0;
            r_write        <= 1'b0;
            r_sum_trigger  <= 1'b0;
        end else begin
            r_write       <= 1'b0;
            r_sum_trigger <= 1'b0;
            case (r_rd_state)
                RD_IDLE: begin
                    // A launch pulse that arrives while busy is simply lost.
                    if (r_ram_ctrl_start) begin
                        r_ram_address <= w_layer_base;
                        r_k           <= 4'd0;
                        r_rd_state    <= RD_READ;
                    end
                end
                RD_READ: begin
                    // The strobe and destination of address k appear one
                    // cycle later, together with the RAM data for k.
                    r_write        <= 1'b1;
                    r_unit_sel     <= r_k[3:2];
                    r_unit_address <= r_k[1:0];
                    if (r_k == LAST_K) begin
                        r_rd_state <= RD_DRAIN;
                    end else begin
                        r_k           <= r_k + 4'd1;
                        r_ram_address <= r_ram_address + 10'd1;
                    end
                end
                RD_DRAIN: begin
                    // Last weight is being written this cycle.
                    r_sum_trigger <= 1'b1;
                    r_rd_state    <= RD_TRIG;
                end
                RD_TRIG: begin
                    r_rd_state <= RD_IDLE;
                end
                default: r_rd_state <= RD_IDLE;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Weight mux
    // -------------------------------------------------------------------------
    logic [3:0] w_write_vec;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_unit_strobe
            assign w_write_vec[gi] = r_write && (r_unit_sel == 2'(gi));
        end
    endgenerate

    assign weight0 = ram_out;
    assign weight1 = ram_out;
    assign weight2 = ram_out;
    assign weight3 = ram_out;
    assign write0  = w_write_vec[0];
    assign write1  = w_write_vec[1];
    assign write2  = w_write_vec[2];
    assign write3  = w_write_vec[3];

    // -------------------------------------------------------------------------
    // Output registers
    // -------------------------------------------------------------------------
    assign RAM_address        = r_ram_address;
    assign layer              = r_layer;
    assign layer_sel          = r_layer_sel;
    assign RAM_Controll_Start = r_ram_ctrl_start;
    assign unit_sel           = r_unit_sel;
    assign unit_address       = r_unit_address;
    assign write              = r_write;
    assign sum_trigger        = r_sum_trigger;

endmodule

// File: tb/tb_nn_layer_weight_loader.sv
// -----------------------------------------------------------------------------
// Testbench for nn_layer_weight_loader.
// A behavioural model (sequencer as layer/busy variables, loads as a start
// cycle plus an offset formula) is compared with the DUT every cycle on the
// falling edge. The stimulus process adds literal spot checks.
// -----------------------------------------------------------------------------
module tb_nn_layer_weight_loader;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       done = 1'b0;
    logic [7:0] ram_out = 8'd0;
    logic [9:0] RAM_address;
    logic [1:0] layer;
    logic       layer_sel;
    logic       RAM_Controll_Start;
    logic [1:0] unit_sel;
    logic [1:0] unit_address;
    logic       write;
    logic       sum_trigger;
    logic [7:0] weight0, weight1, weight2, weight3;
    logic       write0, write1, write2, write3;

    logic [7:0] mem [1024];

    nn_layer_weight_loader #(.LAST_LAYER(2), .LAYER_STRIDE(16)) dut (
        .clk                (clk),
        .reset              (reset),
        .start              (start),
        .done               (done),
        .ram_out            (ram_out),
        .RAM_address        (RAM_address),
        .layer              (layer),
        .layer_sel          (layer_sel),
        .RAM_Controll_Start (RAM_Controll_Start),
        .unit_sel           (unit_sel),
        .unit_address       (unit_address),
        .write              (write),
        .sum_trigger        (sum_trigger),
        .weight0            (weight0),
        .weight1            (weight1),
        .weight2            (weight2),
        .weight3            (weight3),
        .write0             (write0),
        .write1             (write1),
        .write2             (write2),
        .write3             (write3)
    );

    always #5 clk = ~clk;

    // External synchronous-read RAM.
    always @(posedge clk) ram_out <= mem[RAM_address];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------------
    // Behavioural model
    // ---------------------------------------------------------------------
    int cyc = 0;
    int m_layer = 0;
    bit m_busy = 0;          // sequencer inside a pass
    bit m_rcs = 0;           // expected RAM_Controll_Start this cycle
    bit m_load_valid = 0;
    int m_load_s = 0;        // cycle in which the driver accepted the load
    int m_base = 0;
    int m_addr = 0;
    int obs_writes = 0;
    int obs_trigs = 0;

    always @(negedge clk) begin
        int d, k, e_wr, e_trig;
        bit nrcs;
        logic [3:0] wv;
        d = m_load_valid ? (cyc - m_load_s) : -1;
        if (d >= 1 && d <= 16) m_addr = m_base + d - 1;
        e_wr   = (d >= 2 && d <= 17) ? 1 : 0;
        k      = d - 2;
        e_trig = (d == 18) ? 1 : 0;
        wv = {write3, write2, write1, write0};

        chk("layer", layer, m_layer);
        chk("layer_sel", layer_sel, (m_layer != 0) ? 1 : 0);
        chk("RAM_Controll_Start", RAM_Controll_Start, m_rcs);
        chk("RAM_address", RAM_address, m_addr);
        chk("write", write, e_wr);
        chk("sum_trigger", sum_trigger, e_trig);
        chk("write_onehot", $countones(wv), e_wr);
        for (int n = 0; n < 4; n++)
            chk($sformatf("write%0d", n), wv[n], (e_wr != 0 && k / 4 == n) ? 1 : 0);
        if (e_wr != 0) begin
            chk("unit_sel", unit_sel, k / 4);
            chk("unit_address", unit_address, k % 4);
            chk("weight0", weight0, mem[m_base + k]);
            chk("weight1", weight1, mem[m_base + k]);
            chk("weight2", weight2, mem[m_base + k]);
            chk("weight3", weight3, mem[m_base + k]);
        end
        if (write) obs_writes++;
        if (sum_trigger) obs_trigs++;

        // Advance the model using the inputs sampled at the next rising edge.
        if (reset) begin
            m_layer = 0; m_busy = 0; m_rcs = 0; m_load_valid = 0; m_addr = 0;
        end else begin
            nrcs = 0;
            if (m_rcs && !(m_load_valid && cyc <= m_load_s + 18)) begin
                m_load_valid = 1;
                m_load_s     = cyc;
                m_base       = m_layer * 16;
            end
            if (!m_busy) begin
                if (start) begin m_layer = 0; nrcs = 1; m_busy = 1; end
            end else if (done) begin
                if (m_layer < 2) begin m_layer = m_layer + 1; nrcs = 1; end
                else m_busy = 0;
            end
            m_rcs = nrcs;
        end
        cyc++;
    end

    // ---------------------------------------------------------------------
    // Stimulus
    // ---------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_trig(output int waited);
        waited = 0;
        while (!sum_trigger && waited < 200) begin
            tick();
            waited++;
        end
        chk("sum_trigger_seen", sum_trigger, 1);
    endtask

    task automatic pulse_done();
        done = 1'b1;
        tick();
        done = 1'b0;
    endtask

    // One full pass. In literal mode (rnd=0) the RAM must hold word i = i.
    task automatic run_pass(input bit rnd);
        int waited, gap;
        obs_writes = 0;
        obs_trigs  = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        // Now at T+1 == S for layer 0.
        chk("lit_rcs_T1", RAM_Controll_Start, 1);
        chk("lit_layer_T1", layer, 0);
        tick();
        chk("lit_addr_S1", RAM_address, 0);
        for (int i = 0; i < 15; i++) begin
            start = (i == 4) ? 1'b1 : 1'b0;   // ignored: pass already running
            tick();
        end
        start = 1'b0;
        // S+16: last address, write for k=14 (unit 3 slot 2).
        chk("lit_addr_S16", RAM_address, 15);
        chk("lit_unit_S16", unit_sel, 3);
        chk("lit_slot_S16", unit_address, 2);
        chk("lit_write3_S16", write3, 1);
        if (!rnd) chk("lit_weight3_S16", weight3, 14);
        wait_trig(waited);
        chk("lit_trig_latency", waited, 2);
        for (int l = 1; l <= 3; l++) begin
            gap = rnd ? $urandom_range(1, 20) : 10;
            for (int g = 0; g < gap; g++) begin
                start = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
                tick();
            end
            start = 1'b0;
            pulse_done();
            if (l < 3) begin
                chk("lit_layer_next", layer, l);
                chk("lit_layer_sel_next", layer_sel, 1);
                chk("lit_rcs_next", RAM_Controll_Start, 1);
                tick();
                chk("lit_base_addr", RAM_address, 16 * l);
                wait_trig(waited);
                chk("lit_trig_latency_l", waited, 17);
            end else begin
                chk("lit_layer_final", layer, 2);
                chk("lit_rcs_final", RAM_Controll_Start, 0);
            end
        end
        // Done in IDLE must be ignored; no fourth load.
        repeat (5) tick();
        pulse_done();
        repeat (30) tick();
        chk("pass_writes", obs_writes, 48);
        chk("pass_trigs", obs_trigs, 3);
        chk("idle_layer", layer, 2);
    endtask

    initial begin
        int waited;
        for (int i = 0; i < 1024; i++) mem[i] = 8'(i);

        // Reset, then quiet idle period.
        reset = 1'b1;
        repeat (5) tick();
        reset = 1'b0;
        repeat (50) tick();
        chk("idle_addr", RAM_address, 0);
        chk("idle_layer0", layer, 0);
        chk("idle_write", write, 0);

        // Identity-RAM pass with literal checks.
        run_pass(1'b0);

        // Random RAM contents and timing.
        for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
        run_pass(1'b1);

        // Reset at the 8th address of layer 1.
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_trig(waited);
        repeat (3) tick();
        pulse_done();              // now at S of layer 1
        repeat (8) tick();         // S+8: 8th address
        chk("abort_addr", RAM_address, 23);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_layer", layer, 0);
        chk("abort_layer_sel", layer_sel, 0);
        chk("abort_addr0", RAM_address, 0);
        chk("abort_write", write, 0);
        chk("abort_write1", write1, 0);
        chk("abort_unit", unit_sel, 0);
        chk("abort_trig", sum_trigger, 0);
        chk("abort_rcs", RAM_Controll_Start, 0);
        repeat (25) tick();

        // Fresh pass after the abort restarts from layer 0, address 0.
        run_pass(1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Absolute bound on run time.
    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout, expected finish");
        $fatal(1, "timeout");
    end

endmodule
